// File: rtl/bt_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the Bluetooth UART transmitter.
// Grant stays locked to one requester until its last byte or a timeout abort.
module bt_tx_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] data,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic [7:0]     tx_data,
    output logic           tx_send,
    input  logic           tx_busy,
    output logic           err_timeout,
    output logic           active
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE, CAPTURE, LOAD, WAIT_HI, WAIT_LO, NEXT
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] cnt;
    logic [PW-1:0] ptr, gidx, win, idx;
    logic          found, last_q, timed_out, release_pkt;

    assign timed_out = (cnt == TW'(TIMEOUT));
    assign active    = (state != IDLE);

    // Scan starts one past the previous owner so every source gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ack         = '0;
        tx_send     = 1'b0;
        err_timeout = 1'b0;
        release_pkt = 1'b0;
        unique case (state)
            IDLE: begin
                if (found)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                ack       = grant;
                state_nxt = LOAD;
            end
            LOAD: begin
                // Hold off the start pulse while the transmitter is still busy.
                if (!tx_busy) begin
                    tx_send   = 1'b1;
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = WAIT_LO;
                end else if (timed_out) begin
                    err_timeout = 1'b1;
                    release_pkt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        release_pkt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        state_nxt = NEXT;
                    end
                end
            end
            NEXT: begin
                if (req[gidx]) begin
                    state_nxt = CAPTURE;
                end else if (timed_out) begin
                    err_timeout = 1'b1;
                    release_pkt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            gidx    <= '0;
            grant   <= '0;
            tx_data <= '0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state == WAIT_HI || state == NEXT)
                cnt <= cnt + 1'b1;
            if (state == IDLE && found) begin
                grant <= N'(1) << win;
                gidx  <= win;
            end
            if (state == CAPTURE) begin
                tx_data <= data[{gidx, 3'b000} +: 8];
                last_q  <= last[gidx];
            end
            if (release_pkt) begin
                grant <= '0;
                ptr   <= gidx;
            end
        end
    end

endmodule

// File: tb/tb_bt_tx_arbiter.sv
// Directed bench for bt_tx_arbiter with a simple busy-for-20-cycles
// transmitter model that can be switched off to provoke timeouts.
module tb_bt_tx_arbiter;

    localparam int N       = 3;
    localparam int TIMEOUT = 1023;
    localparam int TW      = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_send;
    logic           tx_busy;
    logic           err_timeout;
    logic           active;

    logic model_en;
    int   busy_cnt;
    int   errors = 0;
    int   checks = 0;
    int   c;
    bit   h;

    bt_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .last(last),
        .ack(ack), .grant(grant), .tx_data(tx_data), .tx_send(tx_send),
        .tx_busy(tx_busy), .err_timeout(err_timeout), .active(active)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset)
            busy_cnt <= 0;
        else if (model_en && tx_send)
            busy_cnt <= 20;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt > 0);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // which: 0 ack, 1 tx_send, 2 err_timeout, 3 !active, 4 !tx_busy
    task automatic wait_sig(input int which, input int maxc,
                            output int cycles, output bit hit);
        cycles = 0;
        hit    = 1'b0;
        while (!hit && cycles < maxc) begin
            @(negedge clk);
            cycles++;
            case (which)
                0: hit = |ack;
                1: hit = tx_send;
                2: hit = err_timeout;
                3: hit = !active;
                default: hit = !tx_busy;
            endcase
        end
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        data     = '0;
        last     = '0;
        model_en = 1'b1;
        #12;
        check("rst_grant", grant, 0);
        check("rst_ack", ack, 0);
        check("rst_send", tx_send, 0);
        check("rst_err", err_timeout, 0);
        check("rst_active", active, 0);
        check("rst_txdata", tx_data, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single-byte packet from requester 0
        @(negedge clk);
        req = 3'b001; data[7:0] = 8'h41; last = 3'b001;
        wait_sig(0, 10, c, h);
        check("t1_ack_hit", h, 1);
        check("t1_ack_lat", c, 1);
        check("t1_ack", ack, 3'b001);
        check("t1_grant", grant, 3'b001);
        @(posedge clk); #1;
        req = 3'b000;
        wait_sig(1, 5, c, h);
        check("t1_send_lat", c, 1);
        check("t1_txdata", tx_data, 8'h41);
        check("t1_ack_once", ack, 0);
        wait_sig(3, 60, c, h);
        check("t1_idle", h, 1);
        check("t1_grant_clr", grant, 0);

        // Packet lock: requester 1 sends 3 bytes while requester 2 waits
        req = 3'b110; last = 3'b100;
        data[15:8] = 8'h10; data[23:16] = 8'hEE;
        for (int b = 0; b < 3; b++) begin
            wait_sig(0, 80, c, h);
            check("t2_ack_hit", h, 1);
            check("t2_ack", ack, 3'b010);
            @(posedge clk); #1;
            if (b < 2) begin
                data[15:8] = 8'h11 + 8'(b);
                last[1]    = (b == 1);
            end else begin
                req[1] = 1'b0;
            end
            wait_sig(1, 5, c, h);
            check("t2_send_hit", h, 1);
            check("t2_txdata", tx_data, 8'h10 + 8'(b));
            check("t2_grant_lock", grant, 3'b010);
        end
        wait_sig(0, 80, c, h);
        check("t2_next_ack", ack, 3'b100);
        @(posedge clk); #1;
        req[2] = 1'b0;
        wait_sig(1, 5, c, h);
        check("t2_r2_data", tx_data, 8'hEE);
        wait_sig(3, 60, c, h);
        check("t2_idle", h, 1);

        // Round robin from ptr = 0, all three requesting
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        data = {8'hA2, 8'hA1, 8'hA0};
        last = 3'b111;
        req  = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_sig(0, 80, c, h);
            check("t3_ack", ack, 32'(1) << ((i + 1) % 3));
            if (i == 5) begin
                @(posedge clk); #1;
                req = 3'b000;
            end
            wait_sig(1, 5, c, h);
            check("t3_txdata", tx_data, 8'hA0 + 8'((i + 1) % 3));
        end
        wait_sig(3, 60, c, h);
        check("t3_idle", h, 1);

        // Busy timeout: transmitter never responds
        model_en = 1'b0;
        data = {8'h00, 8'h77, 8'h88};
        last = 3'b011;
        req  = 3'b011;
        wait_sig(0, 10, c, h);
        check("t4_ack", ack, 3'b010);
        @(posedge clk); #1;
        req[1] = 1'b0;
        wait_sig(1, 5, c, h);
        check("t4_txdata", tx_data, 8'h77);
        wait_sig(2, TIMEOUT + 20, c, h);
        check("t4_err_hit", h, 1);
        check("t4_err_time", c, TIMEOUT + 1);
        @(negedge clk);
        check("t4_grant_clr", grant, 0);
        check("t4_err_pulse", err_timeout, 0);
        model_en = 1'b1;
        wait_sig(0, 10, c, h);
        check("t4_next_ack", ack, 3'b001);
        @(posedge clk); #1;
        req = 3'b000;
        wait_sig(1, 5, c, h);
        check("t4_next_data", tx_data, 8'h88);
        wait_sig(3, 60, c, h);
        check("t4_idle", h, 1);

        // Gap timeout: requester 0 goes quiet mid-packet
        data[7:0] = 8'h55; last = 3'b000; req = 3'b001;
        wait_sig(0, 10, c, h);
        check("t5_ack", ack, 3'b001);
        @(posedge clk); #1;
        req = 3'b000;
        wait_sig(1, 5, c, h);
        check("t5_txdata", tx_data, 8'h55);
        wait_sig(4, 40, c, h);
        check("t5_busy_fall", h, 1);
        wait_sig(2, TIMEOUT + 20, c, h);
        check("t5_err_time", c, TIMEOUT + 1);
        check("t5_grant_held", grant, 3'b001);
        wait_sig(1, 50, c, h);
        check("t5_no_send", h, 0);
        check("t5_inactive", active, 0);

        // Async reset during WAIT_LO of a 2-byte packet
        data[7:0] = 8'h61; last = 3'b000; req = 3'b001;
        wait_sig(0, 10, c, h);
        check("t6_ack", ack, 3'b001);
        @(posedge clk); #1;
        data[7:0] = 8'h62; last = 3'b001;
        wait_sig(1, 5, c, h);
        check("t6_txdata", tx_data, 8'h61);
        repeat (5) @(negedge clk);
        check("t6_active_pre", active, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_grant", grant, 0);
        check("t6_ack", ack, 0);
        check("t6_send", tx_send, 0);
        check("t6_err", err_timeout, 0);
        check("t6_active", active, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_sig(0, 10, c, h);
        check("t6_re_ack_lat", c, 1);
        check("t6_re_ack", ack, 3'b001);
        @(posedge clk); #1;
        req = 3'b000;
        wait_sig(1, 5, c, h);
        check("t6_re_data", tx_data, 8'h62);
        wait_sig(3, 60, c, h);
        check("t6_idle", h, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bt_tx_arbiter.md
Name: bt_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single Bluetooth UART transmitter between N byte-stream requesters (sensor, status, debug sources).
Locks the grant to one requester for a whole packet, up to and including its byte flagged last.
Sequences each byte into the transmitter using its send/busy handshake.
Sits between the application sources and the transmitter's data_in/send/busy pins.

Parameters:
N, 3, number of requesters (2..8)
TIMEOUT, 1023, cycles to wait for transmitter busy to rise, or for the granted requester's next byte, before aborting the packet
TW, 10, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  asynchronous, active-high reset
req  in  N  per-requester byte-valid; held until acked
data  in  8*N  requester i byte on data[8i+7:8i]
last  in  N  per-requester flag: the offered byte ends the packet
ack  out  N  one-cycle pulse; the byte of that requester was captured
grant  out  N  one-hot owner of the transmitter; 0 when idle
tx_data  out  8  byte to the transmitter
tx_send  out  1  one-cycle start pulse to the transmitter
tx_busy  in  1  transmitter busy
err_timeout  out  1  one-cycle pulse on packet abort
active  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async) values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0, last-captured flag 0.
- States and transitions:
  - IDLE -> CAPTURE when any req is high.
  - CAPTURE -> LOAD.
  - LOAD -> WAIT_HI.
  - WAIT_HI -> WAIT_LO, or WAIT_HI -> IDLE on timeout.
  - WAIT_LO -> IDLE after the last byte; WAIT_LO -> NEXT otherwise.
  - NEXT -> CAPTURE, or NEXT -> IDLE on timeout.
- Arbitration (IDLE): scan req starting at index ptr+1 mod N, where ptr is the last granted requester.
  - First requester found with req high wins; grant is registered one-hot.
  - With a single requester, it wins every time.
- CAPTURE (one cycle):
  - Latch the granted requester's data and last flag.
  - ack[g] = 1 this cycle only; the requester drops or updates req/data next cycle.
- LOAD: tx_send = 1 for exactly one cycle.
  - tx_data holds the latched byte from LOAD until the next CAPTURE.
  - tx_send is never asserted while tx_busy = 1.
- WAIT_HI: wait for tx_busy = 1. The counter increments each cycle.
  - Counter reaching TIMEOUT: err_timeout pulse, grant cleared, ptr updated to the aborted requester, go to IDLE.
- WAIT_LO: wait for tx_busy = 0, with no timeout because the byte time is bounded by the transmitter.
  - Latched last = 1: clear grant, update ptr, go to IDLE.
  - Otherwise: go to NEXT.
- NEXT: grant stays held; wait for req[g].
  - req[g] high: go to CAPTURE.
  - Counter reaching TIMEOUT: abort exactly as in WAIT_HI.
  - Other requesters' req is ignored while a packet is locked.
- Counter resets to 0 on every state change.
- Minimum per-byte overhead:
  - Controller overhead beyond the transmitter's byte time is CAPTURE + LOAD + NEXT → CAPTURE.
  - A new packet adds IDLE → CAPTURE.
- Simultaneous requests: only the winner is acked; losers keep req high and are served later in round-robin order.
- A req edge arriving in the same cycle as release is not served until the IDLE evaluation in the following cycle.
- Reset mid-packet: immediate return to IDLE with grant = 0 and tx_send = 0. No ack is generated for the in-flight byte; the transmitter is reset by the same reset.
- last and data of non-granted requesters are don't-care.

Test Plan:
- Single-byte packet: req[0] = 1, data0 = 8'h41, last0 = 1.
  - ack[0] pulses for 1 cycle, then tx_send pulses with tx_data = 8'h41.
  - With the model driving tx_busy for 20 cycles, grant returns to 0 and active = 0 after busy falls.
- Packet lock: requester 1 sends 3 bytes 8'h10/8'h11/8'h12 (last on the third) while req[2] is held high throughout.
  - tx_data sequence is 10, 11, 12 with no requester-2 byte interleaved.
  - Requester 2 is granted next.
- Round-robin: req = 3'b111, each a 1-byte packet, starting from ptr = 0.
  - Grant order is 1, 2, 0, and it repeats fairly over 6 packets.
- Busy timeout: transmitter model never raises tx_busy.
  - err_timeout pulses exactly TIMEOUT cycles after entering WAIT_HI.
  - grant goes to 0 and the next requester is served.
- Gap timeout: requester 0 sends byte 8'h55 with last = 0, then drops req.
  - err_timeout pulses TIMEOUT cycles after entering NEXT.
  - The packet is aborted and no further tx_send occurs.
- Async reset: assert reset during WAIT_LO of a 2-byte packet.
  - Without any clock edge, grant, ack, tx_send, err_timeout and active are all 0.
  - After release, a pending req is served normally.
